// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback over a shared datapath.
// Optional feature: define ILLEGAL_TRAP_EN to trap unknown opcodes in a sticky TRAP state.
module mips_multicycle_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             IorD,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             Branch,
  output logic [1:0]       PCSrc,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic             RegDst,
  output logic             MemtoReg,
  output logic             RegWrite,
  output logic             illegal_op,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instr_count
);
  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
                         OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_J = 6'b000010;

  typedef enum logic [3:0] {
    FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3, MEMWB = 4'd4, MEMWR = 4'd5,
    EXEC = 4'd6, ALUWB = 4'd7, BRANCH = 4'd8, ADDIEX = 4'd9, ADDIWB = 4'd10, JUMP = 4'd11
`ifdef ILLEGAL_TRAP_EN
    , TRAP = 4'd12
`endif
  } state_t;

  state_t st, nxt;
  logic   retire;

  always_ff @(posedge clk) begin
    if (reset) begin
      st          <= FETCH;
      instr_count <= '0;
    end else begin
      st <= nxt;
      if (retire) instr_count <= instr_count + CNT_W'(1);
    end
  end

  assign state = st;

  always_comb begin
    nxt        = st;
    retire     = 1'b0;
    mem_req    = 1'b0;
    IorD       = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    PCWrite    = 1'b0;
    Branch     = 1'b0;
    PCSrc      = 2'b00;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ALUOp      = 2'b00;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    RegWrite   = 1'b0;
    illegal_op = 1'b0;
    case (st)
      FETCH: begin
        mem_req = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
        if (mem_ready) nxt = DECODE;
      end
      DECODE: begin
        ALUSrcB = 2'b11;
        case (opcode)
          OP_LW, OP_SW: nxt = MEMADR;
          OP_R:         nxt = EXEC;
          OP_BEQ:       nxt = BRANCH;
          OP_ADDI:      nxt = ADDIEX;
          OP_J:         nxt = JUMP;
`ifdef ILLEGAL_TRAP_EN
          default:      nxt = TRAP;
`else
          default:      nxt = FETCH;  // unknown opcode behaves as an uncounted NOP
`endif
        endcase
      end
      MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        nxt     = (opcode == OP_SW) ? MEMWR : MEMRD;
      end
      MEMRD: begin
        mem_req = 1'b1;
        IorD    = 1'b1;
        if (mem_ready) nxt = MEMWB;
      end
      MEMWB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
        retire   = 1'b1;
        nxt      = FETCH;
      end
      MEMWR: begin
        mem_req  = 1'b1;
        IorD     = 1'b1;
        MemWrite = mem_ready;
        if (mem_ready) begin
          retire = 1'b1;
          nxt    = FETCH;
        end
      end
      EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
        nxt     = ALUWB;
      end
      ALUWB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
        retire   = 1'b1;
        nxt      = FETCH;
      end
      BRANCH: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b01;
        PCSrc   = 2'b01;
        Branch  = 1'b1;
        retire  = 1'b1;
        nxt     = FETCH;
      end
      ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        nxt     = ADDIWB;
      end
      ADDIWB: begin
        RegWrite = 1'b1;
        retire   = 1'b1;
        nxt      = FETCH;
      end
      JUMP: begin
        PCSrc   = 2'b10;
        PCWrite = 1'b1;
        retire  = 1'b1;
        nxt     = FETCH;
      end
`ifdef ILLEGAL_TRAP_EN
      TRAP: illegal_op = 1'b1;  // sticky until reset
`endif
      default: nxt = FETCH;
    endcase
    // Reset presents an idle FETCH: datapath selects as in FETCH, no writes, no request.
    if (reset) begin
      mem_req    = 1'b0;
      IorD       = 1'b0;
      MemWrite   = 1'b0;
      IRWrite    = 1'b0;
      PCWrite    = 1'b0;
      Branch     = 1'b0;
      PCSrc      = 2'b00;
      ALUSrcA    = 1'b0;
      ALUSrcB    = 2'b01;
      ALUOp      = 2'b00;
      RegDst     = 1'b0;
      MemtoReg   = 1'b0;
      RegWrite   = 1'b0;
      illegal_op = 1'b0;
    end
  end
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: per-opcode step plans plus per-step output table, directed then random.
module tb_mips_multicycle_ctrl;
  localparam int CW = 4;  // narrow counter so wrap-around is reached quickly

  logic clk = 1'b0, reset = 1'b1, mem_ready = 1'b0;
  logic [5:0] opcode = 6'd0;
  logic mem_req, IorD, MemWrite, IRWrite, PCWrite, Branch, ALUSrcA, RegDst, MemtoReg, RegWrite, illegal_op;
  logic [1:0] PCSrc, ALUSrcB, ALUOp;
  logic [3:0] state;
  logic [CW-1:0] instr_count;

  mips_multicycle_ctrl #(.CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .mem_req(mem_req), .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite), .PCWrite(PCWrite),
    .Branch(Branch), .PCSrc(PCSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .illegal_op(illegal_op),
    .state(state), .instr_count(instr_count));

  always #5 clk = ~clk;

  int checks = 0, failures = 0;

  typedef struct {
    int mreq, iord, memw, irw, pcw, br, pcsrc, srca, srcb, aluop, regdst, m2r, regw, ill;
  } exp_t;

  // Reference: current step, retired count and the remaining steps of the current instruction.
  int  m_st = 0, m_cnt = 0;
  bit  m_valid = 0;
  int  plan[$];
  int  h_st[$], h_rw[$], h_m2r[$], h_mw[$], h_pcs[$], h_mreq[$], h_ill[$];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0d exp=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic exp_t step_out(int s, int mr);
    exp_t e = '{default: 0};
    case (s)
      0:  begin e.mreq = 1; e.srcb = 1; e.irw = mr; e.pcw = mr; end
      1:  e.srcb = 3;
      2:  begin e.srca = 1; e.srcb = 2; end
      3:  begin e.mreq = 1; e.iord = 1; end
      4:  begin e.m2r = 1; e.regw = 1; end
      5:  begin e.mreq = 1; e.iord = 1; e.memw = mr; end
      6:  begin e.srca = 1; e.aluop = 2; end
      7:  begin e.regdst = 1; e.regw = 1; end
      8:  begin e.srca = 1; e.aluop = 1; e.pcsrc = 1; e.br = 1; end
      9:  begin e.srca = 1; e.srcb = 2; end
      10: e.regw = 1;
      11: begin e.pcsrc = 2; e.pcw = 1; end
      12: e.ill = 1;
      default: ;
    endcase
    return e;
  endfunction

  function automatic void set_plan(logic [5:0] op);
    plan.delete();
    case (op)
      6'b000000: plan = '{6, 7};
      6'b100011: plan = '{2, 3, 4};
      6'b101011: plan = '{2, 5};
      6'b000100: plan = '{8};
      6'b001000: plan = '{9, 10};
      6'b000010: plan = '{11};
      default: ;
    endcase
  endfunction

  task automatic cmp();
    exp_t e;
    if (reset) begin
      e = step_out(0, 0);
      e.mreq = 0;
    end else e = step_out(m_st, int'(mem_ready));
    if (m_valid) begin
      chk("state", int'(state), m_st);
      chk("instr_count", int'(instr_count), m_cnt);
    end
    if (m_valid || reset) begin
      chk("mem_req", int'(mem_req), e.mreq);   chk("MemWrite", int'(MemWrite), e.memw);
      chk("IRWrite", int'(IRWrite), e.irw);    chk("PCWrite", int'(PCWrite), e.pcw);
      chk("Branch", int'(Branch), e.br);       chk("RegWrite", int'(RegWrite), e.regw);
    end
    if (m_valid) begin
      chk("IorD", int'(IorD), e.iord);         chk("PCSrc", int'(PCSrc), e.pcsrc);
      chk("ALUSrcA", int'(ALUSrcA), e.srca);   chk("ALUSrcB", int'(ALUSrcB), e.srcb);
      chk("ALUOp", int'(ALUOp), e.aluop);      chk("RegDst", int'(RegDst), e.regdst);
      chk("MemtoReg", int'(MemtoReg), e.m2r);  chk("illegal_op", int'(illegal_op), e.ill);
    end
  endtask

  task automatic model_update();
    if (reset) begin
      m_st = 0; m_cnt = 0; m_valid = 1; plan.delete();
    end else if (!m_valid || m_st == 12) begin
    end else if (m_st == 0) begin
      if (mem_ready) m_st = 1;
    end else if (m_st == 1) begin
      set_plan(opcode);
`ifdef ILLEGAL_TRAP_EN
      if (plan.size() == 0) m_st = 12;
`else
      if (plan.size() == 0) m_st = 0;
`endif
      else m_st = plan.pop_front();
    end else if ((m_st == 3 || m_st == 5) && !mem_ready) begin
    end else if (plan.size() != 0) m_st = plan.pop_front();
    else begin
      m_st = 0; m_cnt = (m_cnt + 1) % (1 << CW);
    end
  endtask

  task automatic clr_hist();
    h_st.delete(); h_rw.delete(); h_m2r.delete(); h_mw.delete(); h_pcs.delete(); h_mreq.delete(); h_ill.delete();
  endtask

  task automatic cyc();
    @(negedge clk);
    cmp();
    h_st.push_back(int'(state));   h_rw.push_back(int'(RegWrite)); h_m2r.push_back(int'(MemtoReg));
    h_mw.push_back(int'(MemWrite)); h_pcs.push_back(int'(PCSrc));  h_mreq.push_back(int'(mem_req));
    h_ill.push_back(int'(illegal_op));
    @(posedge clk);
    model_update();
    #1;
  endtask

  // One instruction with mem_ready taken from rmask bit i on cycle i.
  task automatic run(input logic [5:0] op, input int n, input logic [15:0] rmask);
    opcode = op;
    clr_hist();
    for (int i = 0; i < n; i++) begin
      mem_ready = rmask[i];
      cyc();
    end
  endtask

  initial begin
    int exp_r[4], exp_lw[8], exp_sw[6], nbeq, r;
    exp_r  = '{0, 1, 6, 7};
    exp_lw = '{0, 1, 2, 3, 3, 3, 3, 4};
    exp_sw = '{0, 1, 2, 5, 5, 5};

    // Reset held for two cycles
    cyc(); cyc();
    chk("rst_state", int'(state), 0);
    chk("rst_count", int'(instr_count), 0);
    chk("rst_mem_req", int'(mem_req), 0);
    reset = 1'b0;

    run(6'b000000, 4, 16'h000F);
    chk("rel_mem_req", h_mreq[0], 1);
    for (int i = 0; i < 4; i++) begin
      chk("r_seq", h_st[i], exp_r[i]);
      chk("r_regwrite", h_rw[i], (i == 3) ? 1 : 0);
    end
    chk("r_back_fetch", int'(state), 0);
    chk("r_count", int'(instr_count), 1);

    run(6'b100011, 8, 16'h00C7);
    for (int i = 0; i < 8; i++) chk("lw_seq", h_st[i], exp_lw[i]);
    chk("lw_memtoreg", h_m2r[7], 1);
    chk("lw_regwrite", h_rw[7], 1);
    chk("lw_back_fetch", int'(state), 0);

    run(6'b101011, 6, 16'h0027);
    for (int i = 0; i < 6; i++) begin
      chk("sw_seq", h_st[i], exp_sw[i]);
      chk("sw_memwrite", h_mw[i], (i == 5) ? 1 : 0);
    end
    chk("sw_back_fetch", int'(state), 0);

    run(6'b000010, 3, 16'h0007);
    chk("j_state", h_st[2], 11);
    chk("j_pcsrc", h_pcs[2], 2);
    chk("j_count", int'(instr_count), 4);

    run(6'b111111, 2, 16'h0003);
`ifdef ILLEGAL_TRAP_EN
    for (int i = 0; i < 3; i++) cyc();
    chk("trap_state", int'(state), 12);
    chk("trap_flag", h_ill[h_ill.size()-1], 1);
    reset = 1'b1; cyc(); reset = 1'b0;
    nbeq = 16;
`else
    chk("nop_state", int'(state), 0);
    chk("nop_seq", h_st[1], 1);
    chk("nop_count", int'(instr_count), 4);
    nbeq = 12;
`endif

    for (int i = 0; i < nbeq; i++) run(6'b000100, 3, 16'h0007);
    chk("wrap_count", int'(instr_count), 0);

    // Reset while a store waits on memory
    run(6'b101011, 4, 16'h0007);
    chk("sw_wait_state", int'(state), 5);
    reset = 1'b1; mem_ready = 1'b1;
    clr_hist();
    cyc();
    chk("abort_memwrite", h_mw[0], 0);
    reset = 1'b0;
    chk("abort_state", int'(state), 0);
    chk("abort_count", int'(instr_count), 0);

    for (int c = 0; c < 4000; c++) begin
      reset = ($urandom_range(0, 299) == 0) || (m_st == 12 && $urandom_range(0, 3) == 0);
      mem_ready = ($urandom_range(0, 3) != 0);
      if (m_st == 0) begin
        r = $urandom_range(0, 15);
        case (r)
          0, 1, 2:   opcode = 6'b000000;
          3, 4, 5:   opcode = 6'b100011;
          6, 7, 8:   opcode = 6'b101011;
          9, 10, 11: opcode = 6'b000100;
          12, 13:    opcode = 6'b001000;
          14:        opcode = 6'b000010;
          default:   opcode = 6'($urandom);
        endcase
      end
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
